// File: rtl/cell_stats_if.sv
// Board-statistics bus: generation events in, board-RAM read port, display-stage results out.
interface cell_stats_if;
  logic        game_mode;
  logic        step_done;
  logic        clear_gen;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [1:0]  rd_data;
  logic [12:0] generation;
  logic [7:0]  cell_a;
  logic [7:0]  cell_b;
  logic [15:0] cell_total;
  logic        busy;
  logic        stats_valid;

  // Environment side: board controller, board RAM and display stage
  modport master (
    output game_mode, step_done, clear_gen, rd_data,
    input  rd_en, rd_addr, generation, cell_a, cell_b, cell_total, busy, stats_valid
  );

  // Statistics counter side
  modport slave (
    input  game_mode, step_done, clear_gen, rd_data,
    output rd_en, rd_addr, generation, cell_a, cell_b, cell_total, busy, stats_valid
  );
endinterface

// File: rtl/cell_stats_counter.sv
// Scans the whole board after every committed generation, counts live cells
// per team and publishes the totals plus a generation count to the display.
module cell_stats_counter #(
  parameter int COLS = 64,
  parameter int ROWS = 48
) (
  input logic         clk,
  input logic         rst,
  cell_stats_if.slave bus
);

  localparam int          N         = COLS * ROWS;
  localparam logic [11:0] LAST_ADDR = 12'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_LATCH
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [11:0] r_addr;
  logic        r_rdValid;
  logic [15:0] r_accTotal;
  logic [11:0] r_accA;
  logic [11:0] r_accB;
  logic [12:0] r_genCount;
  logic        r_pending;
  logic [12:0] r_generation;
  logic [7:0]  r_cellA;
  logic [7:0]  r_cellB;
  logic [15:0] r_cellTotal;
  logic        r_statsValid;
  logic        w_rdEn;
  logic [11:0] w_rdAddr;
  logic        w_busy;
  logic        w_startScan;
  logic [7:0]  w_satA;
  logic [7:0]  w_satB;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // Next state and read-port strobes; a step seen during LATCH chains straight into a new scan
  always_comb begin
    w_nextState = r_state;
    w_rdEn      = 1'b0;
    w_rdAddr    = '0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.step_done) w_nextState = S_SCAN;
      end
      S_SCAN: begin
        w_rdEn   = 1'b1;
        w_rdAddr = r_addr;
        if (r_addr == LAST_ADDR) w_nextState = S_DRAIN;
      end
      S_DRAIN: w_nextState = S_LATCH;
      S_LATCH: w_nextState = (r_pending || bus.step_done) ? S_SCAN : S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  assign w_startScan = (w_nextState == S_SCAN) && (r_state != S_SCAN);
  assign w_satA      = (r_accA > 12'd255) ? 8'hFF : r_accA[7:0];
  assign w_satB      = (r_accB > 12'd255) ? 8'hFF : r_accB[7:0];

  // Address counter walks the board; rd_valid marks the cycle the RAM answers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_rdValid <= 1'b0;
    end else begin
      r_rdValid <= w_rdEn;
      if (w_startScan)             r_addr <= '0;
      else if (r_state == S_SCAN)  r_addr <= r_addr + 12'd1;
    end
  end

  // Live-cell accumulators, cleared as a scan begins
  always_ff @(posedge clk) begin
    if (rst || w_startScan) begin
      r_accTotal <= '0;
      r_accA     <= '0;
      r_accB     <= '0;
    end else if (r_rdValid) begin
      if (bus.rd_data != 2'b00) r_accTotal <= r_accTotal + 16'd1;
      if (bus.rd_data == 2'b01) r_accA     <= r_accA + 12'd1;
      if (bus.rd_data == 2'b10) r_accB     <= r_accB + 12'd1;
    end
  end

  // Generation count and pending-rescan flag; clear_gen beats a simultaneous step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_genCount <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (bus.clear_gen)      r_genCount <= '0;
      else if (bus.step_done) r_genCount <= r_genCount + 13'd1;
      if (r_state == S_LATCH)                         r_pending <= 1'b0;
      else if (bus.step_done && r_state != S_IDLE)    r_pending <= 1'b1;
    end
  end

  // Publish registers, loaded together at the end of LATCH with game_mode sampled there
  always_ff @(posedge clk) begin
    if (rst) begin
      r_generation <= '0;
      r_cellA      <= '0;
      r_cellB      <= '0;
      r_cellTotal  <= '0;
      r_statsValid <= 1'b0;
    end else begin
      r_statsValid <= (r_state == S_LATCH);
      if (r_state == S_LATCH) begin
        r_cellTotal  <= r_accTotal;
        r_cellA      <= bus.game_mode ? w_satA : 8'd0;
        r_cellB      <= bus.game_mode ? w_satB : 8'd0;
        r_generation <= bus.clear_gen ? 13'd0 : r_genCount;
      end else if (bus.clear_gen) begin
        r_generation <= '0;
      end
    end
  end

  assign bus.rd_en       = w_rdEn;
  assign bus.rd_addr     = w_rdAddr;
  assign bus.busy        = w_busy;
  assign bus.generation  = r_generation;
  assign bus.cell_a      = r_cellA;
  assign bus.cell_b      = r_cellB;
  assign bus.cell_total  = r_cellTotal;
  assign bus.stats_valid = r_statsValid;

endmodule

// File: tb/tb_cell_stats_counter.sv
// Self-checking bench for cell_stats_counter: board RAM model, counting model, scenario tasks.
module tb_cell_stats_counter;

  localparam int N = 3072;

  logic       clk = 1'b0;
  logic       rst;
  int         compared   = 0;
  int         mismatched = 0;
  int         genModel   = 0;
  logic [1:0] board [N];

  cell_stats_if bus();

  cell_stats_counter #(.COLS(64), .ROWS(48)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // Board RAM: one-cycle read latency, noise on the bus when not being read
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= board[bus.rd_addr];
    else           bus.rd_data <= 2'($urandom);
  end

  // Reference counts straight from the board contents
  function automatic void countBoard(output int t, output int a, output int b);
    t = 0; a = 0; b = 0;
    for (int i = 0; i < N; i++) begin
      if (board[i] != 2'b00) t++;
      if (board[i] == 2'b01) a++;
      if (board[i] == 2'b10) b++;
    end
  endfunction

  function automatic int publishTeam(input int cnt, input bit mode);
    if (!mode)     return 0;
    if (cnt > 255) return 255;
    return cnt;
  endfunction

  // Issue one step (optionally with clear) and return one tick after the sampling edge
  task automatic pulseStep(input bit withClear);
    @(posedge clk); #1;
    bus.step_done = 1'b1;
    bus.clear_gen = withClear;
    @(posedge clk); #1;
    bus.step_done = 1'b0;
    bus.clear_gen = 1'b0;
    if (withClear) genModel = 0;
    else           genModel = (genModel + 1) % 8192;
  endtask

  task automatic pulseClear();
    @(posedge clk); #1;
    bus.clear_gen = 1'b1;
    @(posedge clk); #1;
    bus.clear_gen = 1'b0;
    genModel = 0;
  endtask

  // Wait (bounded) for stats_valid, optionally injecting events on given cycles
  task automatic waitValid(input int limit, input int switchAt, input bit lateMode,
                           input int stepAt1, input int stepAt2, input int clearAt,
                           output int cycles, output int busyLow);
    cycles  = -1;
    busyLow = 0;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk); #1;
      bus.step_done = 1'b0;
      bus.clear_gen = 1'b0;
      if (bus.stats_valid === 1'b1) begin
        cycles = c;
        break;
      end
      if (bus.busy !== 1'b1) busyLow++;
      if (c == switchAt) bus.game_mode = lateMode;
      if (c == stepAt1 || c == stepAt2) begin
        bus.step_done = 1'b1;
        genModel = (genModel + 1) % 8192;
      end
      if (c == clearAt) begin
        bus.clear_gen = 1'b1;
        genModel = 0;
      end
    end
    bus.step_done = 1'b0;
    bus.clear_gen = 1'b0;
  endtask

  task automatic waitIdle(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(posedge clk); #1;
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.step_done = 1'b1;
    bus.clear_gen = 1'b1;
    @(posedge clk); #1;
    bus.step_done = 1'b0;
    bus.clear_gen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    genModel = 0;
    @(posedge clk); #1;
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %0d expected 0", bus.busy); end
    compared++; if (bus.rd_en !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rd_en: got %0d expected 0", bus.rd_en); end
    compared++; if (bus.rd_addr !== 12'd0) begin mismatched++; $display("[TB] FAIL reset_rd_addr: got %0d expected 0", bus.rd_addr); end
    compared++; if (bus.stats_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stats_valid: got %0d expected 0", bus.stats_valid); end
    compared++; if (bus.generation !== 13'd0) begin mismatched++; $display("[TB] FAIL reset_generation: got %0d expected 0", bus.generation); end
    compared++; if (bus.cell_total !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_cell_total: got %0d expected 0", bus.cell_total); end
    compared++; if (bus.cell_a !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_cell_a: got %0d expected 0", bus.cell_a); end
    compared++; if (bus.cell_b !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_cell_b: got %0d expected 0", bus.cell_b); end
  endtask

  task automatic test_all_dead();
    int sweepErr, cycles, busyLow, lat;
    for (int i = 0; i < N; i++) board[i] = 2'b00;
    bus.game_mode = 1'b0;
    pulseStep(1'b0);
    sweepErr = 0;
    for (int k = 0; k < N; k++) begin
      if (bus.rd_en !== 1'b1 || bus.rd_addr !== 12'(k)) sweepErr++;
      @(posedge clk); #1;
    end
    compared++; if (sweepErr !== 0) begin mismatched++; $display("[TB] FAIL sweep_addresses: got %0d bad cycles expected 0", sweepErr); end
    compared++; if (bus.rd_en !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_rd_en: got %0d expected 0", bus.rd_en); end
    waitValid(100, -1, 1'b0, -1, -1, -1, cycles, busyLow);
    lat = (cycles < 0) ? -1 : N + cycles;
    compared++; if (lat !== 3074) begin mismatched++; $display("[TB] FAIL dead_latency: got %0d expected 3074", lat); end
    compared++; if (bus.cell_total !== 16'd0) begin mismatched++; $display("[TB] FAIL dead_total: got %0d expected 0", bus.cell_total); end
    compared++; if (bus.generation !== 13'(genModel)) begin mismatched++; $display("[TB] FAIL dead_generation: got %0d expected %0d", bus.generation, genModel); end
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL dead_busy_after: got %0d expected 0", bus.busy); end
    @(posedge clk); #1;
    compared++; if (bus.stats_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL dead_valid_one_cycle: got %0d expected 0", bus.stats_valid); end
  endtask

  task automatic test_board_counts();
    int cycles, busyLow, expT, expA, expB, placed, idx;
    bit mode;
    for (int tc = 0; tc < 3; tc++) begin
      if (tc == 0) begin
        for (int i = 0; i < N; i++) board[i] = 2'b00;
        placed = 0;
        while (placed < 357) begin
          idx = $urandom_range(0, N - 1);
          if (board[idx] == 2'b00) begin
            board[idx] = (placed < 300) ? 2'b01 : (placed < 350) ? 2'b10 : 2'b11;
            placed++;
          end
        end
        mode = 1'b1;
      end else if (tc == 1) begin
        mode = 1'b0;
      end else begin
        for (int i = 0; i < N; i++)
          board[i] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        mode = 1'($urandom);
      end
      countBoard(expT, expA, expB);
      bus.game_mode = ~mode;
      pulseStep(1'b0);
      waitValid(4000, 1000, mode, -1, -1, -1, cycles, busyLow);
      compared++; if (cycles !== 3074) begin mismatched++; $display("[TB] FAIL board%0d_latency: got %0d expected 3074", tc, cycles); end
      compared++; if (bus.cell_total !== 16'(expT)) begin mismatched++; $display("[TB] FAIL board%0d_total: got %0d expected %0d", tc, bus.cell_total, expT); end
      compared++; if (bus.cell_a !== 8'(publishTeam(expA, mode))) begin mismatched++; $display("[TB] FAIL board%0d_cell_a: got %0d expected %0d", tc, bus.cell_a, publishTeam(expA, mode)); end
      compared++; if (bus.cell_b !== 8'(publishTeam(expB, mode))) begin mismatched++; $display("[TB] FAIL board%0d_cell_b: got %0d expected %0d", tc, bus.cell_b, publishTeam(expB, mode)); end
      compared++; if (bus.generation !== 13'(genModel)) begin mismatched++; $display("[TB] FAIL board%0d_generation: got %0d expected %0d", tc, bus.generation, genModel); end
    end
  endtask

  task automatic test_back_to_back();
    int cycles, busyLow;
    pulseClear();
    pulseStep(1'b0);
    waitValid(4000, -1, 1'b0, 100, -1, -1, cycles, busyLow);
    compared++; if (cycles !== 3074) begin mismatched++; $display("[TB] FAIL b2b_first_latency: got %0d expected 3074", cycles); end
    compared++; if (bus.generation !== 13'(genModel)) begin mismatched++; $display("[TB] FAIL b2b_first_generation: got %0d expected %0d", bus.generation, genModel); end
    compared++; if (bus.busy !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_busy_at_publish: got %0d expected 1", bus.busy); end
    waitValid(4000, -1, 1'b0, 50, 60, -1, cycles, busyLow);
    compared++; if (cycles !== 3074) begin mismatched++; $display("[TB] FAIL b2b_second_latency: got %0d expected 3074", cycles); end
    compared++; if (busyLow !== 0) begin mismatched++; $display("[TB] FAIL b2b_no_idle_gap: got %0d idle cycles expected 0", busyLow); end
    compared++; if (bus.generation !== 13'(genModel)) begin mismatched++; $display("[TB] FAIL b2b_second_generation: got %0d expected %0d", bus.generation, genModel); end
    waitValid(4000, -1, 1'b0, -1, -1, -1, cycles, busyLow);
    compared++; if (cycles !== 3074) begin mismatched++; $display("[TB] FAIL b2b_third_latency: got %0d expected 3074", cycles); end
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_single_pending: got busy %0d expected 0", bus.busy); end
  endtask

  task automatic test_clear_gen();
    int cycles, busyLow;
    bit ok;
    pulseStep(1'b0);
    waitValid(4000, -1, 1'b0, -1, -1, 100, cycles, busyLow);
    compared++; if (cycles !== 3074) begin mismatched++; $display("[TB] FAIL clear_midscan_latency: got %0d expected 3074", cycles); end
    compared++; if (bus.generation !== 13'd0) begin mismatched++; $display("[TB] FAIL clear_midscan_generation: got %0d expected 0", bus.generation); end
    pulseStep(1'b0);
    waitValid(4000, -1, 1'b0, -1, -1, -1, cycles, busyLow);
    pulseClear();
    compared++; if (bus.generation !== 13'd0) begin mismatched++; $display("[TB] FAIL clear_published: got %0d expected 0", bus.generation); end
    @(posedge clk); #1;
    bus.step_done = 1'b1;
    repeat (41) begin
      @(posedge clk); #1;
      genModel = (genModel + 1) % 8192;
    end
    bus.step_done = 1'b0;
    waitIdle(8000, ok);
    compared++; if (!ok || bus.generation !== 13'(genModel)) begin mismatched++; $display("[TB] FAIL count_to_41: got %0d expected %0d (idle %0d)", bus.generation, genModel, ok); end
    pulseStep(1'b1);
    waitValid(4000, -1, 1'b0, -1, -1, -1, cycles, busyLow);
    compared++; if (cycles !== 3074) begin mismatched++; $display("[TB] FAIL clear_step_latency: got %0d expected 3074", cycles); end
    compared++; if (bus.generation !== 13'd0) begin mismatched++; $display("[TB] FAIL clear_step_generation: got %0d expected 0", bus.generation); end
  endtask

  task automatic test_wrap();
    int cycles, busyLow;
    bit ok;
    @(posedge clk); #1;
    bus.step_done = 1'b1;
    repeat (8192) begin
      @(posedge clk); #1;
      genModel = (genModel + 1) % 8192;
    end
    bus.step_done = 1'b0;
    waitIdle(8000, ok);
    compared++; if (!ok || bus.generation !== 13'(genModel)) begin mismatched++; $display("[TB] FAIL wrap_generation: got %0d expected %0d (idle %0d)", bus.generation, genModel, ok); end
    pulseStep(1'b0);
    waitValid(4000, -1, 1'b0, -1, -1, -1, cycles, busyLow);
    compared++; if (bus.generation !== 13'(genModel)) begin mismatched++; $display("[TB] FAIL wrap_plus_one: got %0d expected %0d", bus.generation, genModel); end
  endtask

  task automatic test_reset_mid_scan();
    int validSeen;
    pulseStep(1'b0);
    repeat (1500) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    genModel = 0;
    compared++; if (bus.rd_en !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_rd_en: got %0d expected 0", bus.rd_en); end
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_busy: got %0d expected 0", bus.busy); end
    compared++; if (bus.generation !== 13'd0 || bus.cell_total !== 16'd0) begin mismatched++; $display("[TB] FAIL abort_outputs: got gen %0d total %0d expected 0 0", bus.generation, bus.cell_total); end
    compared++; if (bus.cell_a !== 8'd0 || bus.cell_b !== 8'd0) begin mismatched++; $display("[TB] FAIL abort_teams: got a %0d b %0d expected 0 0", bus.cell_a, bus.cell_b); end
    validSeen = 0;
    repeat (4000) begin
      @(posedge clk); #1;
      if (bus.stats_valid !== 1'b0) validSeen++;
    end
    compared++; if (validSeen !== 0) begin mismatched++; $display("[TB] FAIL abort_no_valid: got %0d pulses expected 0", validSeen); end
  endtask

  // Run every scenario in order and report
  initial begin
    rst           = 1'b1;
    bus.game_mode = 1'b0;
    bus.step_done = 1'b0;
    bus.clear_gen = 1'b0;
    for (int i = 0; i < N; i++) board[i] = 2'b00;
    test_reset();
    test_all_dead();
    test_board_counts();
    test_back_to_back();
    test_clear_gen();
    test_wrap();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cell_stats_counter.md
CELL_STATS_COUNTER -- requirements
Module: cell_stats_counter

Interface
REQ-001 SHALL have parameters: COLS, default 64, board width in cells; ROWS, default 48, board height in cells; total cells N = COLS*ROWS = 3072.
REQ-002 SHALL have ports: clk  in  1  single system clock, all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: game_mode  in  1  0 = single-colour mode, 1 = two-team mode.
REQ-005 SHALL have ports: step_done  in  1  one-cycle pulse; the board has committed a new generation.
REQ-006 SHALL have ports: clear_gen  in  1  one-cycle pulse; a new game has started.
REQ-007 SHALL have ports: rd_en  out  1  board-RAM read strobe.
REQ-008 SHALL have ports: rd_addr  out  12  cell address, row*COLS+col.
REQ-009 SHALL have ports: rd_data  in  2  cell state, valid exactly 1 cycle after rd_en: 00 dead, 01 team A, 10 team B, 11 alive/no team.
REQ-010 SHALL have ports: generation  out  13  published generation count, to the 7-seg display stage.
REQ-011 SHALL have ports: cell_a  out  8  team-A live count, to the display stage.
REQ-012 SHALL have ports: cell_b  out  8  team-B live count, to the display stage.
REQ-013 SHALL have ports: cell_total  out  16  all live cells, to the display stage.
REQ-014 SHALL have ports: busy  out  1  scan in progress.
REQ-015 SHALL have ports: stats_valid  out  1  one-cycle pulse when the outputs update.

Function
REQ-016 SHALL implement FSM IDLE -> SCAN -> DRAIN -> LATCH -> IDLE.
REQ-017 IDLE SHALL go to SCAN on the edge that samples step_done=1.
REQ-018 SCAN SHALL hold rd_en=1 with rd_addr = 0,1,...,N-1 in consecutive cycles, then go to DRAIN after address N-1 is issued.
REQ-019 DRAIN SHALL take one cycle, accumulate the last rd_data, then go to LATCH.
REQ-020 LATCH SHALL take one cycle, then go to IDLE.
REQ-021 rd_en SHALL be 0 in every state other than SCAN; rd_addr SHALL be 0 when idle.
REQ-022 Accumulation SHALL use rd_data sampled on the cycle after each rd_en: total += (data != 00); A += (data == 01); B += (data == 10).
REQ-023 The internal total accumulator SHALL be 16 bits and cannot overflow for N <= 65535.
REQ-024 The A and B accumulators SHALL be 12 bits; cell_a and cell_b SHALL saturate at 255 when published.
REQ-025 On the LATCH->IDLE edge, cell_total, cell_a, cell_b and generation SHALL update together, and stats_valid SHALL be 1 for exactly the following cycle.
REQ-026 stats_valid SHALL first be high 3074 cycles after the edge that sampled step_done (N=3072).
REQ-027 The accumulators SHALL clear on entry to SCAN.
REQ-028 In game_mode=0, cell_a and cell_b SHALL publish as 0; cell_total SHALL be unaffected by game_mode.
REQ-029 A step_done pulse SHALL increment the internal generation count by 1, modulo 8192 (8191 -> 0).
REQ-030 The published generation SHALL take the internal count only on the LATCH->IDLE update.
REQ-031 clear_gen SHALL zero both the internal and the published generation on the next edge without disturbing a running scan.
REQ-032 If clear_gen and step_done arrive in the same cycle, the internal count SHALL become 0, not 1, and the scan SHALL still start.
REQ-033 step_done while busy SHALL increment the count and set a pending flag; further pulses SHALL increment the count but set no extra flag.
REQ-034 With pending set, LATCH SHALL go directly to SCAN (pending cleared) instead of IDLE; stats_valid still pulses.
REQ-035 busy SHALL be 1 in SCAN, DRAIN and LATCH, and 0 in IDLE.
REQ-036 game_mode SHALL be sampled at LATCH only, so a mid-scan change takes effect at publish.

Reset
REQ-037 On rst=1 at an edge, state SHALL become IDLE.
REQ-038 On reset, all outputs SHALL be 0, with pending, accumulators and the internal generation cleared.
REQ-039 Reset during a scan SHALL abort it; no stats_valid SHALL follow.
REQ-040 rst SHALL have priority over step_done and clear_gen in the same cycle.

Verification
REQ-041 Board all dead, mode 0, one step_done -> rd_addr sweeps 0..3071; stats_valid at +3074 cycles; total=0, generation=1.
REQ-042 Board with 300 cells 01, 50 cells 10, 7 cells 11; mode 1 -> total=357, cell_a=255 (saturated), cell_b=50; same board in mode 0 -> cell_a=cell_b=0, total=357.
REQ-043 Second step_done issued 100 cycles into a scan -> back-to-back scans with no IDLE cycle between; the second publish shows generation=2.
REQ-044 clear_gen and step_done in the same cycle with internal count 41 -> publish shows generation=0; then 8192 steps from 0 -> generation wraps to 0.
REQ-045 rst asserted at scan cycle 1500 -> all outputs 0, rd_en=0, and no stats_valid within the next 4000 cycles.
